// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES request arbiter: sequencer states,
// data width and the round-robin pick function used by the arbiter.
package aes_arb_pkg;

    localparam int AES_W    = 128;
    localparam int MAX_N    = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Search valid[] starting at ptr and wrapping at n; first hit wins.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]    valid,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t res;
        int    cand;
        res = '0;
        for (int k = 0; k < MAX_N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((k < n) && !res.found && valid[cand[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// N-way round-robin priority picker. Purely combinational: the caller owns
// the rotating pointer and advances it after each accepted grant.
module aes_rr_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            found,
    output logic [N-1:0]    grant_oh
);

    logic [MAX_N-1:0]    valid_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    pick_t               pick;

    // Widen the request vector and pointer to the fixed width the helper expects.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        ptr_ext            = '0;
        ptr_ext[ID_W-1:0]  = ptr;
    end

    assign pick  = rr_pick(valid_ext, ptr_ext, N);
    assign grant = pick.idx[ID_W-1:0];
    // The range test can never reject a real pick; it keeps a bad index from
    // ever turning into a grant.
    assign found = pick.found && ({1'b0, pick.idx} < 5'(N));

    // One-hot form of the grant, all-zero when nobody is requesting.
    always_comb begin
        grant_oh = '0;
        if (found) begin
            grant_oh[grant] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES cipher core between N requesters. A round-robin arbiter picks
// a request in IDLE, the sequencer pulses the core load, waits for done under
// a watchdog, then presents the tagged ciphertext on the response channel.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*AES_W-1:0]   req_key,
    input  logic [N*AES_W-1:0]   req_text,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [AES_W-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 aes_ld,
    output logic [AES_W-1:0]     aes_key,
    output logic [AES_W-1:0]     aes_text_in,
    input  logic [AES_W-1:0]     aes_text_out,
    input  logic                 aes_done
);

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              found;
    logic [N-1:0]      grant_oh;
    logic              accept;
    logic              timed_out;
    logic [TMR_W-1:0]  timer;
    logic [AES_W-1:0]  key_q;
    logic [AES_W-1:0]  text_q;
    logic [ID_W-1:0]   id_q;
    logic [AES_W-1:0]  rsp_data_q;
    logic              rsp_err_q;

    aes_rr_arbiter #(
        .N (N)
    ) u_arb (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .found    (found),
        .grant_oh (grant_oh)
    );

    // Ready is combinational from valid, so any pick made in IDLE is a handshake.
    assign accept    = (state == IDLE) && found;
    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

    // Sequencer state register; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer transitions; done takes priority over the watchdog in BUSY.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = LOAD;
            LOAD:    next_state = BUSY;
            BUSY:    if (aes_done || timed_out) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and core-control outputs decoded from the current state.
    always_comb begin
        req_ready = '0;
        aes_ld    = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    req_ready = grant_oh;
            LOAD:    aes_ld    = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the winning request and rotate priority past the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= '0;
            text_q <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            key_q  <= req_key[int'(grant)*AES_W +: AES_W];
            text_q <= req_text[int'(grant)*AES_W +: AES_W];
            id_q   <= grant;
            rr_ptr <= (grant == ID_W'(N - 1)) ? '0 : grant + ID_W'(1);
        end
    end

    // Watchdog: cleared while loading, counts every BUSY cycle without done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state == LOAD) begin
            timer <= '0;
        end else if ((state == BUSY) && !aes_done && !timed_out) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Response payload is written only on leaving BUSY, so it holds through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state == BUSY) begin
            if (aes_done) begin
                rsp_data_q <= aes_text_out;
                rsp_err_q  <= 1'b0;
            end else if (timed_out) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign rsp_id      = id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign aes_key     = key_q;
    assign aes_text_in = text_q;

endmodule
